// File: rtl/mux_bram_frame_buf_if.sv
// Readout stream bus of the ping-pong frame buffer (AXI-Stream subset).
interface mux_bram_frame_buf_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              m_tuser;

  modport master (output m_tdata, output m_tvalid, output m_tlast, output m_tuser, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, input m_tuser, output m_tready);
endinterface

// File: rtl/mux_bram_frame_buf.sv
// Two-bank ping-pong frame buffer: packer writes one bank while the other streams out.
// Readout: 1-cycle BRAM latency, 1 word / 2 cycles; stall holds the word, both-full locks the writer.
module mux_bram_frame_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int CODE_W = 5
) (
  input  logic                 clk_120,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    we_code,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 frame_start,
  input  logic                 sk_valid,
  output logic                 locked_bram_once,
  output logic                 flag_otv,
  output logic [15:0]          ovf_words,
  mux_bram_frame_buf_if.master m
);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SHOW} rstate_t;

  wstate_t ws, ws_n;
  rstate_t rs, rs_n;

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [LEN_W-1:0]  len [2];
  logic [1:0]        full, set_mask, clr_mask, full_kept;
  logic              wr_bank, wr_bank_n, rd_bank;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n, eff_addr, rd_addr, rd_addr_n;
  logic [LEN_W-1:0]  fill_n;
  logic              frame_start_q, sk_valid_q, fs_rise, sk_fall, we;
  logic              close_frame, mem_we, rd_fetch, rd_release;

  assign we        = |we_code;
  assign fs_rise   = frame_start & ~frame_start_q;
  assign sk_fall   = ~sk_valid & sk_valid_q;
  // A bank released by the reader this cycle is already free for the writer.
  assign full_kept = full & ~clr_mask;

  always_comb begin
    rs_n       = rs;
    rd_addr_n  = rd_addr;
    clr_mask   = '0;
    rd_fetch   = 1'b0;
    rd_release = 1'b0;
    case (rs)
      R_IDLE: if (full[rd_bank]) begin
        rs_n      = R_FETCH;
        rd_addr_n = '0;
      end
      R_FETCH: begin
        rd_fetch = 1'b1;
        rs_n     = R_SHOW;
      end
      R_SHOW: if (m.m_tready) begin
        if (m.m_tlast) begin
          rd_release        = 1'b1;
          clr_mask[rd_bank] = 1'b1;
          rs_n              = R_IDLE;
        end else begin
          rd_addr_n = rd_addr + 1'b1;
          rs_n      = R_FETCH;
        end
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_comb begin
    ws_n        = ws;
    wr_addr_n   = wr_addr;
    wr_bank_n   = wr_bank;
    set_mask    = '0;
    mem_we      = 1'b0;
    close_frame = 1'b0;
    // A frame restart rewinds to address 0 and a coincident write lands there.
    eff_addr    = fs_rise ? '0 : wr_addr;
    fill_n      = {1'b0, eff_addr} + LEN_W'(we);
    case (ws)
      W_IDLE: if (fs_rise) begin
        ws_n      = W_FILL;
        wr_addr_n = '0;
      end
      W_FILL: begin
        mem_we      = we;
        wr_addr_n   = fill_n[ADDR_W-1:0];
        close_frame = (we && eff_addr == LAST_ADDR) || (sk_fall && !fs_rise && fill_n != '0);
        if (close_frame) begin
          set_mask[wr_bank] = 1'b1;
          wr_bank_n         = ~wr_bank;
          wr_addr_n         = '0;
          if (full_kept[~wr_bank]) ws_n = W_WAIT;
          else if (sk_fall && !fs_rise) ws_n = W_IDLE;
        end else if (sk_fall && !fs_rise) begin
          ws_n = W_IDLE;
        end
      end
      W_WAIT: if (!full[wr_bank]) begin
        ws_n      = W_FILL;
        wr_addr_n = '0;
      end
      default: ws_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_120 or negedge rst_n) begin
    if (!rst_n) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
    end
  end

  always_ff @(posedge clk_120 or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q    <= 1'b0;
      sk_valid_q       <= 1'b0;
      wr_addr          <= '0;
      wr_bank          <= 1'b0;
      rd_addr          <= '0;
      rd_bank          <= 1'b0;
      full             <= '0;
      len[0]           <= '0;
      len[1]           <= '0;
      locked_bram_once <= 1'b0;
      flag_otv         <= 1'b0;
      ovf_words        <= '0;
      m.m_tdata        <= '0;
      m.m_tvalid       <= 1'b0;
      m.m_tlast        <= 1'b0;
      m.m_tuser        <= 1'b0;
    end else begin
      frame_start_q    <= frame_start;
      sk_valid_q       <= sk_valid;
      wr_addr          <= wr_addr_n;
      wr_bank          <= wr_bank_n;
      rd_addr          <= rd_addr_n;
      full             <= (full | set_mask) & ~clr_mask;
      if (close_frame) len[wr_bank] <= fill_n;
      locked_bram_once <= (ws_n == W_WAIT);
      flag_otv         <= rd_release;
      if (rd_release) rd_bank <= ~rd_bank;
      if (ws == W_WAIT && we && ovf_words != 16'hFFFF) ovf_words <= ovf_words + 16'd1;
      if (rd_fetch) begin
        m.m_tdata  <= mem[{rd_bank, rd_addr}];
        m.m_tvalid <= 1'b1;
        m.m_tlast  <= ({1'b0, rd_addr} == len[rd_bank] - LEN_W'(1));
        m.m_tuser  <= rd_bank;
      end else if (m.m_tvalid && m.m_tready) begin
        m.m_tvalid <= 1'b0;
        m.m_tlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_120) begin
    if (mem_we) mem[{wr_bank, eff_addr}] <= wr_data;
  end
endmodule

// File: tb/tb_mux_bram_frame_buf.sv
// Bench for the ping-pong frame buffer: frame-level reference model plus table-driven frame scenarios.
module tb_mux_bram_frame_buf;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  logic              clk_120 = 1'b0;
  logic              rst_n = 1'b0;
  logic [4:0]        we_code = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              frame_start = 1'b0;
  logic              sk_valid = 1'b0;
  logic              locked_bram_once, flag_otv;
  logic [15:0]       ovf_words;

  mux_bram_frame_buf_if #(.DATA_W(DATA_W)) sif ();

  mux_bram_frame_buf dut (
    .clk_120          (clk_120),
    .rst_n            (rst_n),
    .we_code          (we_code),
    .wr_data          (wr_data),
    .frame_start      (frame_start),
    .sk_valid         (sk_valid),
    .locked_bram_once (locked_bram_once),
    .flag_otv         (flag_otv),
    .ovf_words        (ovf_words),
    .m                (sif.master)
  );

  always #5 clk_120 = ~clk_120;

  typedef struct {
    logic [31:0] d;
    bit          last;
    bit          user;
  } beat_t;

  typedef struct {
    int          pre;
    int          n;
    logic [31:0] base;
    bit          sk;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_lastv;
    bit          exp_user;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Frame-level model: words collect into a partial frame, closed frames queue up as expected beats.
  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [31:0] part_q[$];
  bit          m_fill = 1'b0;
  int          frame_no = 0, closed = 0, drained = 0, m_ovf = 0;
  int          otv_cnt = 0, hs_cnt = 0;
  bit          prev_stall = 1'b0, prev_otv = 1'b0;
  beat_t       prev_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic void m_close();
    beat_t b;
    for (int i = 0; i < part_q.size(); i++) begin
      b.d    = part_q[i];
      b.last = (i == part_q.size() - 1);
      b.user = bit'(frame_no % 2);
      exp_q.push_back(b);
    end
    frame_no++;
    closed++;
    part_q.delete();
  endfunction

  function automatic void m_write(input logic [31:0] d);
    if (!m_fill) return;
    if (closed - drained >= 2) begin
      if (m_ovf < 65535) m_ovf++;
      return;
    end
    part_q.push_back(d);
    if (part_q.size() == DEPTH) m_close();
  endfunction

  function automatic void m_fs();
    m_fill = 1'b1;
    part_q.delete();
  endfunction

  function automatic void m_skfall();
    if (m_fill && part_q.size() > 0) m_close();
    m_fill = 1'b0;
  endfunction

  function automatic void m_reset();
    exp_q.delete();
    part_q.delete();
    got_q.delete();
    m_fill = 1'b0;
    frame_no = 0;
    closed = 0;
    drained = 0;
    m_ovf = 0;
  endfunction

  always @(negedge clk_120) begin : mon
    beat_t g, e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_otv   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", sif.m_tdata, prev_beat.d);
        check("stall_ctl", {29'b0, sif.m_tvalid, sif.m_tlast, sif.m_tuser},
              {29'b0, 1'b1, prev_beat.last, prev_beat.user});
      end
      if (sif.m_tvalid && sif.m_tready) begin
        g.d = sif.m_tdata; g.last = sif.m_tlast; g.user = sif.m_tuser;
        got_q.push_back(g);
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 'h%0h, expected no word", g.d);
        end else begin
          e = exp_q.pop_front();
          check("word_data", g.d, e.d);
          check("word_flags", {30'b0, g.last, g.user}, {30'b0, e.last, e.user});
          if (e.last) drained++;
        end
      end
      if (flag_otv) begin
        otv_cnt++;
        check("otv_width", {31'b0, prev_otv}, 32'd0);
      end
      prev_otv   = flag_otv;
      prev_stall = sif.m_tvalid && !sif.m_tready;
      prev_beat.d = sif.m_tdata; prev_beat.last = sif.m_tlast; prev_beat.user = sif.m_tuser;
    end
  end

  task automatic tick();
    @(posedge clk_120);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    m_fs();
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic write_word(input logic [31:0] d, input bit wait_lock);
    int n;
    n = 0;
    if (wait_lock) begin
      while (locked_bram_once && n < 4000) begin
        we_code = '0;
        tick();
        n++;
      end
      if (locked_bram_once) check("lock_wait_timeout", {31'b0, locked_bram_once}, 32'd0);
    end
    we_code = 5'($urandom_range(1, 31));
    wr_data = d;
    m_write(d);
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sif.m_tvalid) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, {31'b0, sif.m_tvalid}, 32'd0);
    check({tag, "_tdata"}, sif.m_tdata, 32'd0);
    check({tag, "_tlast"}, {31'b0, sif.m_tlast}, 32'd0);
    check({tag, "_tuser"}, {31'b0, sif.m_tuser}, 32'd0);
    check({tag, "_locked"}, {31'b0, locked_bram_once}, 32'd0);
    check({tag, "_otv"}, {31'b0, flag_otv}, 32'd0);
    check({tag, "_ovf"}, {16'b0, ovf_words}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   otv0, h0, n, lasts, bad_user;
    bit   done_w;

    vt[0] = '{0, 256, 32'd0, 1'b0, 256, 32'd0, 32'd255, 1'b0};
    vt[1] = '{0, 10, 32'd0, 1'b1, 10, 32'd0, 32'd9, 1'b1};
    vt[2] = '{7, 256, 32'd100, 1'b0, 256, 32'd100, 32'd355, 1'b0};
    vt[3] = '{0, 1, 32'd77, 1'b1, 1, 32'd77, 32'd77, 1'b1};
    vt[4] = '{3, 20, 32'd500, 1'b1, 20, 32'd500, 32'd519, 1'b0};

    sif.m_tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Both banks filled with the reader stalled, then three words that must be dropped.
    sk_valid = 1'b1;
    pulse_fs();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      write_word(32'(i), 1'b0);
      if (i == 2 * DEPTH - 2) check("lock_early", {31'b0, locked_bram_once}, 32'd0);
    end
    check("lock_set", {31'b0, locked_bram_once}, 32'd1);
    for (int k = 0; k < 3; k++) write_word(32'(1000 + k), 1'b0);
    we_code = '0;
    tick();
    check("ovf_count", {16'b0, ovf_words}, 32'(m_ovf));
    check("head_valid", {31'b0, sif.m_tvalid}, 32'd1);
    otv0 = otv_cnt;
    sif.m_tready = 1'b1;
    wait_drain(3000);
    check("lock_cleared", {31'b0, locked_bram_once}, 32'd0);
    check("lock_otv", 32'(otv_cnt - otv0), 32'd2);
    check("ovf_hold", {16'b0, ovf_words}, 32'(m_ovf));

    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      otv0 = otv_cnt;
      sk_valid = 1'b1;
      pulse_fs();
      if (vt[v].pre > 0) begin
        for (int i = 0; i < vt[v].pre; i++) write_word(32'(9000 + i), 1'b1);
        we_code = '0;
        pulse_fs();
      end
      for (int i = 0; i < vt[v].n; i++) write_word(vt[v].base + 32'(i), 1'b1);
      we_code = '0;
      if (vt[v].sk) begin
        sk_valid = 1'b0;
        m_skfall();
        tick();
      end
      wait_drain(3000);
      check("vec_count", 32'(got_q.size()), 32'(vt[v].exp_n));
      if (got_q.size() > 0) begin
        check("vec_first", got_q[0].d, vt[v].exp_first);
        check("vec_lastv", got_q[got_q.size()-1].d, vt[v].exp_lastv);
        check("vec_lastflag", {31'b0, got_q[got_q.size()-1].last}, 32'd1);
        lasts = 0;
        bad_user = 0;
        foreach (got_q[i]) begin
          if (got_q[i].last) lasts++;
          if (got_q[i].user != vt[v].exp_user) bad_user++;
        end
        check("vec_nlast", 32'(lasts), 32'd1);
        check("vec_user", 32'(bad_user), 32'd0);
      end
      check("vec_otv", 32'(otv_cnt - otv0), 32'd1);
    end

    // Four full banks of random data under random backpressure.
    otv0 = otv_cnt;
    sk_valid = 1'b1;
    pulse_fs();
    done_w = 1'b0;
    fork
      begin
        for (int i = 0; i < 4 * DEPTH; i++) write_word($urandom, 1'b1);
        we_code = '0;
        done_w = 1'b1;
      end
      begin
        n = 0;
        while (!(done_w && exp_q.size() == 0) && n < 20000) begin
          sif.m_tready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
      end
    join
    sif.m_tready = 1'b1;
    wait_drain(3000);
    check("rand_otv", 32'(otv_cnt - otv0), 32'd4);
    check("rand_ovf", {16'b0, ovf_words}, 32'(m_ovf));
    check("rand_locked", {31'b0, locked_bram_once}, 32'd0);

    // Reset in the middle of a bank readout.
    sif.m_tready = 1'b0;
    pulse_fs();
    for (int i = 0; i < DEPTH; i++) write_word(32'(5000 + i), 1'b1);
    we_code = '0;
    h0 = hs_cnt;
    sif.m_tready = 1'b1;
    n = 0;
    while (hs_cnt < h0 + 40 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_word40", 32'(hs_cnt - h0), 32'd40);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    m_reset();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_fs();
    for (int i = 0; i < DEPTH; i++) write_word(32'(2000 + i), 1'b1);
    we_code = '0;
    wait_drain(3000);
    check("post_rst_count", 32'(got_q.size()), 32'(DEPTH));
    if (got_q.size() > 0) begin
      check("post_rst_first", got_q[0].d, 32'd2000);
      check("post_rst_user", {31'b0, got_q[0].user}, 32'd0);
      check("post_rst_lastv", got_q[got_q.size()-1].d, 32'd2255);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
